// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: states, opcodes, ALU ops,
// datapath mux codes and the decoded-instruction payload.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IF     = 4'd0,
        S_ID     = 4'd1,
        S_EXE_AL = 4'd2,
        S_EXE_B  = 4'd3,
        S_EXE_LS = 4'd4,
        S_MEM    = 4'd5,
        S_WB_AL  = 4'd6,
        S_WB_LD  = 4'd7,
        S_HALT   = 4'd8
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BLTZ  = 6'b000001;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_JR  = 6'b001000;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_SLT   = 4'd4,
        ALU_RTYPE = 4'd5
    } alu_op_e;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_RS     = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MEM = 2'b01;
    localparam logic [1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        CLS_ILL,
        CLS_J,
        CLS_JAL,
        CLS_JR,
        CLS_HALT,
        CLS_BR,
        CLS_LS,
        CLS_AL
    } ins_class_e;

    typedef enum logic [1:0] {
        BR_EQ,
        BR_NE,
        BR_LTZ
    } br_kind_e;

    typedef struct packed {
        ins_class_e cls;
        br_kind_e   br;
        logic       is_rtype;
        logic       is_lw;
        logic       alu_src_a;
        logic       alu_src_b;
        logic       ext_src;
        alu_op_e    alu_op;
    } decode_t;

    function automatic logic br_taken(input br_kind_e br, input logic zero, input logic sign);
        case (br)
            BR_EQ:   return zero;
            BR_NE:   return !zero;
            BR_LTZ:  return sign;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/op_decoder.sv
// Combinational op/func decode into instruction class plus the ALU/extend
// settings that class needs in its execute cycle.
module op_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic [5:0] op,
    input  logic [5:0] func,
    output decode_t    dec
);

    always_comb begin
        dec        = '0;
        dec.cls    = CLS_ILL;
        dec.br     = BR_EQ;
        dec.alu_op = ALU_ADD;
        // HALT_OP is configurable, so it wins over any fixed opcode it may alias
        if (op == HALT_OP) begin
            dec.cls = CLS_HALT;
        end else begin
            case (op)
                OP_RTYPE: begin
                    dec.is_rtype = 1'b1;
                    if (func == FN_JR) begin
                        dec.cls = CLS_JR;
                    end else begin
                        dec.cls       = CLS_AL;
                        dec.alu_op    = ALU_RTYPE;
                        dec.alu_src_a = (func == FN_SLL);
                    end
                end
                OP_J:   dec.cls = CLS_J;
                OP_JAL: dec.cls = CLS_JAL;
                OP_BEQ: begin
                    dec.cls    = CLS_BR;
                    dec.br     = BR_EQ;
                    dec.alu_op = ALU_SUB;
                end
                OP_BNE: begin
                    dec.cls    = CLS_BR;
                    dec.br     = BR_NE;
                    dec.alu_op = ALU_SUB;
                end
                OP_BLTZ: begin
                    dec.cls    = CLS_BR;
                    dec.br     = BR_LTZ;
                    dec.alu_op = ALU_ADD;
                end
                OP_LW, OP_SW: begin
                    dec.cls       = CLS_LS;
                    dec.is_lw     = (op == OP_LW);
                    dec.alu_src_b = 1'b1;
                    dec.ext_src   = 1'b1;
                    dec.alu_op    = ALU_ADD;
                end
                OP_ADDIU, OP_SLTI: begin
                    dec.cls       = CLS_AL;
                    dec.alu_src_b = 1'b1;
                    dec.ext_src   = 1'b1;
                    dec.alu_op    = (op == OP_ADDIU) ? ALU_ADD : ALU_SLT;
                end
                OP_ANDI, OP_ORI: begin
                    dec.cls       = CLS_AL;
                    dec.alu_src_b = 1'b1;
                    dec.ext_src   = 1'b0;
                    dec.alu_op    = (op == OP_ANDI) ? ALU_AND : ALU_OR;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM: steps each instruction through IF/ID/EXE/MEM/WB and
// drives the shared-datapath strobes, with memory wait states and global hold.
module multicycle_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned CNT_W   = $clog2(MEM_LAT + 1),
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       sign,
    input  logic       hold,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       InsMemRW,
    output logic       ExtSrc,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [3:0] ALUOp,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] WBSrc,
    output logic [1:0] PCSrc,
    output logic [3:0] state,
    output logic       halted,
    output logic       illegal
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

    state_e           state_q;
    state_e           state_d;
    state_e           cur;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    decode_t          dec;

    op_decoder #(
        .HALT_OP (HALT_OP)
    ) u_dec (
        .op   (op),
        .func (func),
        .dec  (dec)
    );

    // While reset is held the outputs already look like the IF state
    assign cur    = Reset ? state_q : S_IF;
    assign state  = cur;
    assign halted = (cur == S_HALT);

    always_ff @(posedge CLK) begin
        if (!Reset) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = cur;
        cnt_d    = cnt_q;
        PCWrite  = 1'b0;
        IRWrite  = 1'b0;
        InsMemRW = 1'b0;
        ExtSrc   = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 1'b0;
        ALUOp    = ALU_ADD;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        RegWrite = 1'b0;
        RegDst   = RD_RT;
        WBSrc    = WB_ALU;
        PCSrc    = PC_PLUS4;
        illegal  = 1'b0;

        case (cur)
            S_IF: begin
                InsMemRW = 1'b1;
                IRWrite  = 1'b1;
                state_d  = S_ID;
            end
            S_ID: begin
                case (dec.cls)
                    CLS_J, CLS_JAL: begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_JUMP;
                        state_d = S_IF;
                        if (dec.cls == CLS_JAL) begin
                            RegWrite = 1'b1;
                            RegDst   = RD_RA;
                            WBSrc    = WB_PC4;
                        end
                    end
                    CLS_JR: begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_RS;
                        state_d = S_IF;
                    end
                    CLS_HALT: state_d = S_HALT;
                    CLS_BR:   state_d = S_EXE_B;
                    CLS_LS:   state_d = S_EXE_LS;
                    CLS_AL:   state_d = S_EXE_AL;
                    default: begin
                        PCWrite = 1'b1;
                        PCSrc   = PC_PLUS4;
                        illegal = 1'b1;
                        state_d = S_IF;
                    end
                endcase
            end
            S_EXE_AL: begin
                ALUSrcA = dec.alu_src_a;
                ALUSrcB = dec.alu_src_b;
                ExtSrc  = dec.ext_src;
                ALUOp   = dec.alu_op;
                state_d = S_WB_AL;
            end
            S_WB_AL: begin
                RegWrite = 1'b1;
                WBSrc    = WB_ALU;
                RegDst   = dec.is_rtype ? RD_RD : RD_RT;
                PCWrite  = 1'b1;
                PCSrc    = PC_PLUS4;
                state_d  = S_IF;
            end
            S_EXE_B: begin
                ALUOp   = dec.alu_op;
                PCWrite = 1'b1;
                PCSrc   = br_taken(dec.br, zero, sign) ? PC_BRANCH : PC_PLUS4;
                state_d = S_IF;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSrc  = 1'b1;
                ALUOp   = ALU_ADD;
                cnt_d   = '0;
                state_d = S_MEM;
            end
            S_MEM: begin
                MemRead = dec.is_lw;
                // The store commits and PC advances only in the final wait cycle
                if (cnt_q == CNT_LAST) begin
                    if (dec.is_lw) begin
                        state_d = S_WB_LD;
                    end else begin
                        MemWrite = 1'b1;
                        PCWrite  = 1'b1;
                        PCSrc    = PC_PLUS4;
                        state_d  = S_IF;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB_LD: begin
                RegWrite = 1'b1;
                WBSrc    = WB_MEM;
                RegDst   = RD_RT;
                PCWrite  = 1'b1;
                PCSrc    = PC_PLUS4;
                state_d  = S_IF;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase

        if (!Reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            MemRead  = 1'b0;
            illegal  = 1'b0;
        end else if (hold && cur != S_HALT) begin
            state_d  = cur;
            cnt_d    = cnt_q;
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: each instruction is expanded into its expected cycle
// sequence from the instruction-level rules, then replayed with random stalls.
module tb_multicycle_control_unit;
    import cpu_ctrl_pkg::*;

    localparam int unsigned LAT  = 3;
    localparam logic [5:0]  HALT = 6'b111111;

    logic       CLK = 1'b0;
    logic       Reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       sign = 1'b0;
    logic       hold = 1'b0;
    logic       PCWrite, IRWrite, InsMemRW, ExtSrc, ALUSrcA, ALUSrcB;
    logic [3:0] ALUOp;
    logic       MemRead, MemWrite, RegWrite;
    logic [1:0] RegDst, WBSrc, PCSrc;
    logic [3:0] state;
    logic       halted, illegal;

    multicycle_control_unit #(
        .MEM_LAT (LAT),
        .HALT_OP (HALT)
    ) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .op       (op),
        .func     (func),
        .zero     (zero),
        .sign     (sign),
        .hold     (hold),
        .PCWrite  (PCWrite),
        .IRWrite  (IRWrite),
        .InsMemRW (InsMemRW),
        .ExtSrc   (ExtSrc),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .RegWrite (RegWrite),
        .RegDst   (RegDst),
        .WBSrc    (WBSrc),
        .PCSrc    (PCSrc),
        .state    (state),
        .halted   (halted),
        .illegal  (illegal)
    );

    always #5 CLK = ~CLK;

    // strb bits: 7 PCWrite, 6 IRWrite, 5 InsMemRW, 4 MemRead, 3 MemWrite, 2 RegWrite, 1 illegal, 0 halted
    typedef struct {
        logic [3:0] st;
        logic [7:0] strb;
        logic [1:0] pcsrc;
        logic [3:0] rd_wb;
        logic [6:0] alu;
        logic [6:0] alu_mask;
    } step_t;

    int    n_cmp = 0;
    int    n_err = 0;
    step_t steps[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic step_t mk(input logic [3:0] st);
        step_t s;
        s.st = st; s.strb = '0; s.pcsrc = '0; s.rd_wb = '0; s.alu = '0; s.alu_mask = '0;
        return s;
    endfunction

    task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z, input logic sg);
        step_t s;
        steps.delete();
        s = mk(S_IF); s.strb[6] = 1'b1; s.strb[5] = 1'b1; steps.push_back(s);
        s = mk(S_ID);
        if (o == HALT) begin
            steps.push_back(s);
        end else if (o == OP_J || o == OP_JAL || (o == OP_RTYPE && f == 6'b001000)) begin
            s.strb[7] = 1'b1;
            s.pcsrc   = (o == OP_RTYPE) ? 2'b11 : 2'b10;
            if (o == OP_JAL) begin s.strb[2] = 1'b1; s.rd_wb = 4'b1010; end
            steps.push_back(s);
        end else if (o == OP_BEQ || o == OP_BNE || o == OP_BLTZ) begin
            steps.push_back(s);
            s = mk(S_EXE_B); s.strb[7] = 1'b1;
            s.pcsrc = ((o == OP_BEQ && z) || (o == OP_BNE && !z) || (o == OP_BLTZ && sg)) ? 2'b01 : 2'b00;
            s.alu = {3'b000, (o == OP_BLTZ) ? 4'(ALU_ADD) : 4'(ALU_SUB)};
            s.alu_mask = 7'b1101111;
            steps.push_back(s);
        end else if (o == OP_LW || o == OP_SW) begin
            steps.push_back(s);
            s = mk(S_EXE_LS); s.alu = {3'b011, 4'(ALU_ADD)}; s.alu_mask = 7'h7f; steps.push_back(s);
            for (int k = 0; k < int'(LAT); k++) begin
                s = mk(S_MEM); s.strb[4] = (o == OP_LW);
                if (k == int'(LAT) - 1 && o == OP_SW) begin s.strb[3] = 1'b1; s.strb[7] = 1'b1; end
                steps.push_back(s);
            end
            if (o == OP_LW) begin
                s = mk(S_WB_LD); s.strb[7] = 1'b1; s.strb[2] = 1'b1; s.rd_wb = 4'b0001;
                steps.push_back(s);
            end
        end else if (o == OP_RTYPE || o == OP_ADDIU || o == OP_SLTI || o == OP_ANDI || o == OP_ORI) begin
            steps.push_back(s);
            s = mk(S_EXE_AL); s.alu_mask = 7'h7f;
            if (o == OP_RTYPE) begin
                s.alu = {(f == 6'b000000), 2'b00, 4'(ALU_RTYPE)}; s.alu_mask = 7'b1101111;
            end
            else if (o == OP_ADDIU) s.alu = {3'b011, 4'(ALU_ADD)};
            else if (o == OP_SLTI)  s.alu = {3'b011, 4'(ALU_SLT)};
            else if (o == OP_ANDI)  s.alu = {3'b010, 4'(ALU_AND)};
            else                    s.alu = {3'b010, 4'(ALU_OR)};
            steps.push_back(s);
            s = mk(S_WB_AL); s.strb[7] = 1'b1; s.strb[2] = 1'b1;
            s.rd_wb = (o == OP_RTYPE) ? 4'b0100 : 4'b0000;
            steps.push_back(s);
        end else begin
            s.strb[7] = 1'b1; s.strb[1] = 1'b1; s.pcsrc = 2'b00;
            steps.push_back(s);
        end
    endtask

    task automatic check_step(input step_t s, input logic h);
        step_t e = s;
        if (h && e.st != S_HALT) begin
            e.strb[7] = 1'b0; e.strb[6] = 1'b0; e.strb[3] = 1'b0; e.strb[2] = 1'b0; e.strb[1] = 1'b0;
        end
        chk("state", 32'(state), 32'(e.st));
        chk("strobes", 32'({PCWrite, IRWrite, InsMemRW, MemRead, MemWrite, RegWrite, illegal, halted}), 32'(e.strb));
        if (e.strb[7]) chk("pcsrc", 32'(PCSrc), 32'(e.pcsrc));
        if (e.strb[2]) chk("regdst_wbsrc", 32'({RegDst, WBSrc}), 32'(e.rd_wb));
        if (e.alu_mask != 7'd0)
            chk("alu_ctrl", 32'({ALUSrcA, ALUSrcB, ExtSrc, ALUOp} & e.alu_mask), 32'(e.alu & e.alu_mask));
    endtask

    // Replays steps[0..upto-1]; stalls don't consume a step, random stalls are capped
    task automatic run_steps(input int upto, input int hold_pct, input int hold_idx,
                             input int hold_len, output int pcw_seen);
        int   i = 0;
        int   guard = 0;
        int   held = 0;
        logic h;
        pcw_seen = 0;
        while (i < upto) begin
            h = (i == hold_idx && held < hold_len) ||
                (guard < 300 && int'($urandom_range(99)) < hold_pct);
            if (i == hold_idx && held < hold_len) held++;
            hold = h;
            @(negedge CLK);
            check_step(steps[i], h);
            if (PCWrite) pcw_seen++;
            @(posedge CLK); #1;
            if (!h) i++;
            guard++;
        end
        hold = 1'b0;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input logic sg, input int hold_pct);
        int pc;
        op = o; func = f; zero = z; sign = sg;
        build(o, f, z, sg);
        run_steps(steps.size(), hold_pct, -1, 0, pc);
        chk("pc_writes", 32'(pc), 32'd1);
    endtask

    logic [5:0] legal_ops [12] = '{OP_RTYPE, OP_BLTZ, OP_J, OP_JAL, OP_BEQ, OP_BNE,
                                   OP_ADDIU, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW};
    logic [5:0] func_pool [5] = '{6'b100000, 6'b100010, 6'b000000, 6'b001000, 6'b101010};

    initial begin
        int    pc;
        step_t rs;
        step_t hs;
        logic [5:0] o;
        logic       is_legal;
        rs = mk(S_IF); rs.strb = 8'b0010_0000;
        hs = mk(S_HALT); hs.strb = 8'b0000_0001;

        // Reset state
        @(negedge CLK); check_step(rs, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK); check_step(rs, 1'b0);
        @(posedge CLK); #1;
        Reset = 1'b1;

        // Directed instructions
        run_instr(OP_RTYPE, 6'b100000, 1'b0, 1'b0, 0);   // add
        run_instr(OP_RTYPE, 6'b000000, 1'b0, 1'b0, 0);   // sll
        run_instr(OP_LW,    6'b000000, 1'b0, 1'b0, 0);
        run_instr(OP_BEQ,   6'b000000, 1'b1, 1'b0, 0);
        run_instr(OP_BEQ,   6'b000000, 1'b0, 1'b0, 0);
        run_instr(OP_BLTZ,  6'b000000, 1'b0, 1'b1, 0);
        run_instr(OP_BNE,   6'b000000, 1'b1, 1'b0, 0);
        run_instr(OP_JAL,   6'b000000, 1'b0, 1'b0, 0);
        run_instr(OP_RTYPE, 6'b001000, 1'b0, 1'b0, 0);   // jr
        run_instr(6'b010101, 6'b000000, 1'b0, 1'b0, 0);  // undecoded
        run_instr(OP_ORI,   6'b000000, 1'b0, 1'b0, 0);

        // sw stalled for 4 cycles on its first MEM cycle
        op = OP_SW; func = '0; zero = 1'b0; sign = 1'b0;
        build(OP_SW, 6'b0, 1'b0, 1'b0);
        run_steps(steps.size(), 0, 3, 4, pc);
        chk("sw_pc_writes", 32'(pc), 32'd1);

        // Reset asserted for 2 cycles in the middle of an lw MEM phase
        op = OP_LW;
        build(OP_LW, 6'b0, 1'b0, 1'b0);
        run_steps(4, 0, -1, 0, pc);
        Reset = 1'b0;
        repeat (2) begin
            @(negedge CLK); check_step(rs, 1'b0);
            @(posedge CLK); #1;
        end
        Reset = 1'b1;
        run_instr(OP_J, 6'b000000, 1'b0, 1'b0, 0);

        // Randomized instruction stream with random stalls
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(9) == 0) begin
                o = OP_RTYPE;
                for (int t = 0; t < 100; t++) begin
                    o = 6'($urandom_range(63));
                    is_legal = (o == HALT);
                    foreach (legal_ops[k]) if (legal_ops[k] == o) is_legal = 1'b1;
                    if (!is_legal) break;
                end
            end else begin
                o = legal_ops[$urandom_range(11)];
            end
            if (o == HALT) o = OP_J;
            run_instr(o, func_pool[$urandom_range(4)], 1'($urandom_range(1)),
                      1'($urandom_range(1)), 20);
        end

        // HALT parks the core regardless of hold until reset
        op = HALT;
        build(HALT, 6'b0, 1'b0, 1'b0);
        run_steps(steps.size(), 0, -1, 0, pc);
        for (int k = 0; k < 6; k++) begin
            hold = 1'($urandom_range(1));
            @(negedge CLK); check_step(hs, hold);
            @(posedge CLK); #1;
        end
        hold = 1'b0;
        Reset = 1'b0;
        @(negedge CLK); check_step(rs, 1'b0);
        @(posedge CLK); #1;
        Reset = 1'b1;
        run_instr(OP_ADDIU, 6'b000000, 1'b0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
